// File: rtl/key_bit_deserializer.sv
// Serial key-bit capture: assembles qualified SDRD bits into words,
// hands them off with valid/ack and tracks overrun/stall errors.
module key_bit_deserializer #(
    parameter int          WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int          TIMEOUT   = 255,
    parameter logic [15:0] SIGNATURE = 16'h00A5,
    localparam int         CW        = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sser_n,
    input  logic             ba13,
    input  logic             ba12,
    input  logic             br_w,
    input  logic             bus_stb,
    input  logic             sdrd,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    input  logic             word_ack,
    output logic             sig_match,
    output logic             overrun,
    output logic             stall_err,
    input  logic             err_clr,
    output logic [CW-1:0]    bit_count
);

    localparam logic [WIDTH-1:0] SIG   = SIGNATURE[WIDTH-1:0];
    localparam logic [CW-1:0]    LAST  = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    ONE   = CW'(1);
    localparam logic [15:0]      TLAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic [15:0]      timer;
    logic             take;

    assign take = bus_stb & ~sser_n & ~ba13 & ba12 & br_w;

    always_comb begin
        shifted = '0;
        if (MSB_FIRST)
            shifted = {shreg[WIDTH-2:0], sdrd};
        else
            shifted = {sdrd, shreg[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            sig_match  <= 1'b0;
            overrun    <= 1'b0;
            stall_err  <= 1'b0;
            bit_count  <= '0;
            timer      <= '0;
        end else begin
            // Clear first so an error set below in the same cycle wins.
            if (err_clr) begin
                overrun   <= 1'b0;
                stall_err <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (take) begin
                        shreg     <= shifted;
                        bit_count <= ONE;
                        timer     <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (take) begin
                        shreg <= shifted;
                        timer <= '0;
                        if (bit_count == LAST) begin
                            word       <= shifted;
                            word_valid <= 1'b1;
                            sig_match  <= (shifted == SIG);
                            bit_count  <= '0;
                            state      <= FULL;
                        end else begin
                            bit_count <= bit_count + ONE;
                        end
                    end else if (timer == TLAST) begin
                        stall_err <= 1'b1;
                        bit_count <= '0;
                        timer     <= '0;
                        state     <= IDLE;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                FULL: begin
                    if (word_ack) begin
                        word_valid <= 1'b0;
                        sig_match  <= 1'b0;
                        if (take) begin
                            shreg     <= shifted;
                            bit_count <= ONE;
                            timer     <= '0;
                            state     <= SHIFT;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (take) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_bit_deserializer.sv
// Bench for key_bit_deserializer: MSB-first and LSB-first instances
// share stimulus and are checked against a bit-list model every cycle.
module tb_key_bit_deserializer;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst, sser_n, ba13, ba12, br_w, bus_stb, sdrd, word_ack, err_clr;
    logic [7:0] word0, word1;
    logic v0, v1, s0, s1, o0, o1, e0, e1;
    logic [3:0] bc0, bc1;

    int n_cmp = 0;
    int n_bad = 0;
    bit run = 1'b0;

    always #5 clk = ~clk;

    key_bit_deserializer #(
        .WIDTH(8), .MSB_FIRST(1'b1), .TIMEOUT(TO), .SIGNATURE(16'h00A5)
    ) u0 (
        .clk(clk), .rst(rst), .sser_n(sser_n), .ba13(ba13), .ba12(ba12),
        .br_w(br_w), .bus_stb(bus_stb), .sdrd(sdrd), .word(word0),
        .word_valid(v0), .word_ack(word_ack), .sig_match(s0),
        .overrun(o0), .stall_err(e0), .err_clr(err_clr), .bit_count(bc0)
    );

    key_bit_deserializer #(
        .WIDTH(8), .MSB_FIRST(1'b0), .TIMEOUT(TO), .SIGNATURE(16'h00A5)
    ) u1 (
        .clk(clk), .rst(rst), .sser_n(sser_n), .ba13(ba13), .ba12(ba12),
        .br_w(br_w), .bus_stb(bus_stb), .sdrd(sdrd), .word(word1),
        .word_valid(v1), .word_ack(word_ack), .sig_match(s1),
        .overrun(o1), .stall_err(e1), .err_clr(err_clr), .bit_count(bc1)
    );

    // Model: list of received bits, full flag, idle count; m=0 MSB-first.
    int         mn[2];
    int         midle[2];
    bit [7:0]   mb[2];
    bit         mfull[2];
    bit [7:0]   mword[2];
    bit         movr[2];
    bit         mstall[2];

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic model_step();
        bit t;
        bit ov, st;
        t = bus_stb && !sser_n && !ba13 && ba12 && br_w;
        for (int m = 0; m < 2; m++) begin
            ov = 1'b0;
            st = 1'b0;
            if (rst) begin
                mn[m] = 0; midle[m] = 0; mfull[m] = 0; mword[m] = 0;
                movr[m] = 0; mstall[m] = 0;
                continue;
            end
            if (mfull[m]) begin
                if (word_ack) begin
                    mfull[m] = 0;
                    if (t) begin
                        mb[m][0] = sdrd; mn[m] = 1; midle[m] = 0;
                    end
                end else if (t) begin
                    ov = 1'b1;
                end
            end else if (mn[m] == 0) begin
                if (t) begin
                    mb[m][0] = sdrd; mn[m] = 1; midle[m] = 0;
                end
            end else if (t) begin
                mb[m][mn[m]] = sdrd;
                mn[m]++;
                midle[m] = 0;
                if (mn[m] == 8) begin
                    for (int i = 0; i < 8; i++)
                        if (m == 0) mword[m][7-i] = mb[m][i];
                        else        mword[m][i]   = mb[m][i];
                    mfull[m] = 1;
                    mn[m] = 0;
                end
            end else begin
                midle[m]++;
                if (midle[m] == TO) begin
                    st = 1'b1; mn[m] = 0; midle[m] = 0;
                end
            end
            movr[m]   = ov || (movr[m] && !err_clr);
            mstall[m] = st || (mstall[m] && !err_clr);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("word0", {8'h0, word0}, {8'h0, mword[0]});
            chk("word1", {8'h0, word1}, {8'h0, mword[1]});
            chk("valid0", {15'h0, v0}, {15'h0, mfull[0]});
            chk("valid1", {15'h0, v1}, {15'h0, mfull[1]});
            chk("sig0", {15'h0, s0},
                {15'h0, mfull[0] && mword[0] == 8'hA5});
            chk("sig1", {15'h0, s1},
                {15'h0, mfull[1] && mword[1] == 8'hA5});
            chk("ovr0", {15'h0, o0}, {15'h0, movr[0]});
            chk("ovr1", {15'h0, o1}, {15'h0, movr[1]});
            chk("stall0", {15'h0, e0}, {15'h0, mstall[0]});
            chk("stall1", {15'h0, e1}, {15'h0, mstall[1]});
            chk("bc0", {12'h0, bc0}, 16'(mn[0]));
            chk("bc1", {12'h0, bc1}, 16'(mn[1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        run = 1'b1;
        @(negedge clk);
    endtask

    task automatic cyc(input logic stb, input logic d,
                       input logic ack = 1'b0, input logic clr = 1'b0);
        rst = 1'b0; sser_n = 1'b0; ba13 = 1'b0; ba12 = 1'b1; br_w = 1'b1;
        bus_stb = stb; sdrd = d; word_ack = ack; err_clr = clr;
        tick();
    endtask

    task automatic take_bit(input logic d);
        cyc(1'b1, d);
    endtask

    task automatic bad(input int kind);
        cyc(1'b1, 1'b1);
        // cyc already advanced; redo with a disqualified qualifier
    endtask

    task automatic disq(input int kind);
        rst = 1'b0; sser_n = 1'b0; ba13 = 1'b0; ba12 = 1'b1; br_w = 1'b1;
        bus_stb = 1'b1; sdrd = 1'b1; word_ack = 1'b0; err_clr = 1'b0;
        case (kind % 5)
            0: sser_n = 1'b1;
            1: ba13 = 1'b1;
            2: br_w = 1'b0;
            3: ba12 = 1'b0;
            default: bus_stb = 1'b0;
        endcase
        tick();
    endtask

    task automatic send8(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) take_bit(v[i]);
    endtask

    initial begin
        logic [7:0] pat;
        rst = 1'b1; sser_n = 1'b0; ba13 = 1'b0; ba12 = 1'b1; br_w = 1'b1;
        bus_stb = 1'b1; sdrd = 1'b1; word_ack = 1'b0; err_clr = 1'b0;
        tick();
        chk("rst_word", {8'h0, word0}, 16'h0);
        chk("rst_valid", {15'h0, v0}, 16'h0);
        chk("rst_bc", {12'h0, bc0}, 16'h0);
        chk("rst_ovr", {15'h0, o0}, 16'h0);
        chk("rst_stall", {15'h0, e0}, 16'h0);

        pat = 8'hA5;
        for (int i = 7; i >= 1; i--) take_bit(pat[i]);
        chk("a5_pre_valid", {15'h0, v0}, 16'h0);
        chk("a5_pre_bc", {12'h0, bc0}, 16'd7);
        take_bit(pat[0]);
        chk("a5_valid", {15'h0, v0}, 16'h1);
        chk("a5_word0", {8'h0, word0}, 16'h00A5);
        chk("a5_sig0", {15'h0, s0}, 16'h1);
        chk("a5_word1", {8'h0, word1}, 16'h00A5);
        chk("a5_sig1", {15'h0, s1}, 16'h1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("ack_valid", {15'h0, v0}, 16'h0);
        chk("ack_sig", {15'h0, s0}, 16'h0);

        send8(8'h80);
        chk("w80_word0", {8'h0, word0}, 16'h0080);
        chk("w80_word1", {8'h0, word1}, 16'h0001);
        chk("w80_sig1", {15'h0, s1}, 16'h0);
        cyc(1'b0, 1'b0, 1'b1);

        pat = 8'h3A;
        for (int i = 7; i >= 0; i--) begin
            disq(i);
            if (i == 4) chk("disq_bc", {12'h0, bc0}, 16'd3);
            take_bit(pat[i]);
        end
        chk("disq_word0", {8'h0, word0}, 16'h003A);
        chk("disq_word1", {8'h0, word1}, 16'h005C);
        cyc(1'b0, 1'b0, 1'b1);

        take_bit(1'b1); take_bit(1'b1); take_bit(1'b1);
        repeat (3) cyc(1'b0, 1'b0);
        chk("to_pre_stall", {15'h0, e0}, 16'h0);
        chk("to_pre_bc", {12'h0, bc0}, 16'd3);
        cyc(1'b0, 1'b0);
        chk("to_stall", {15'h0, e0}, 16'h1);
        chk("to_bc", {12'h0, bc0}, 16'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("to_clr", {15'h0, e0}, 16'h0);

        take_bit(1'b1); take_bit(1'b1); take_bit(1'b1);
        repeat (3) cyc(1'b0, 1'b0);
        take_bit(1'b1);
        chk("edge_stall", {15'h0, e0}, 16'h0);
        chk("edge_bc", {12'h0, bc0}, 16'd4);
        repeat (4) take_bit(1'b1);
        chk("ff_word", {8'h0, word0}, 16'h00FF);

        take_bit(1'b0);
        chk("ovr_set", {15'h0, o0}, 16'h1);
        chk("ovr_word", {8'h0, word0}, 16'h00FF);
        cyc(1'b1, 1'b1, 1'b1);
        chk("acktake_valid", {15'h0, v0}, 16'h0);
        chk("acktake_bc", {12'h0, bc0}, 16'd1);
        chk("acktake_ovr", {15'h0, o0}, 16'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_clr", {15'h0, o0}, 16'h0);
        repeat (7) take_bit(1'b0);
        chk("full2_valid", {15'h0, v0}, 16'h1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("setwins_ovr", {15'h0, o0}, 16'h1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);

        repeat (5) take_bit(1'b1);
        chk("mid_bc", {12'h0, bc0}, 16'd5);
        rst = 1'b1; bus_stb = 1'b1; word_ack = 1'b1;
        tick();
        chk("rst2_bc", {12'h0, bc0}, 16'h0);
        chk("rst2_valid", {15'h0, v0}, 16'h0);
        chk("rst2_word", {8'h0, word0}, 16'h0);
        send8(8'hA5);
        chk("post_word0", {8'h0, word0}, 16'h00A5);
        chk("post_sig0", {15'h0, s0}, 16'h1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0);

        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
